// File: rtl/tmds_pattern_gen_pkg.sv
// Shared definitions for the TMDS test-symbol generator.
// Holds the pattern mode codes and the run-control state encoding used by
// tmds_pattern_gen and tmds_pattern_lane.
package tmds_pattern_gen_pkg;

  localparam logic [2:0] PAT_PRBS    = 3'd0;
  localparam logic [2:0] PAT_CONST   = 3'd1;
  localparam logic [2:0] PAT_CLOCK   = 3'd2;
  localparam logic [2:0] PAT_COUNTER = 3'd3;
  localparam logic [2:0] PAT_WALK    = 3'd4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/tmds_pattern_lane.sv
// One lane of the TMDS test-symbol generator: holds the lane's current symbol
// and steps it through the selected pattern.
// Ports:
//   clk, rst     clock, async active-high reset
//   reload       load initial symbol for load_mode and latch the mode
//   advance      step to the next symbol of the latched mode
//   load_mode    pattern select (taken on reload)
//   load_const   CONST-mode symbol (taken on reload)
//   sym          registered current symbol
module tmds_pattern_lane
  import tmds_pattern_gen_pkg::*;
#(
  parameter int                      SYMBOL_WIDTH = 10,
  parameter logic [SYMBOL_WIDTH-1:0] LFSR_POLY    = 10'h240,
  parameter logic [SYMBOL_WIDTH-1:0] SEED         = 10'h3FF
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    reload,
  input  logic                    advance,
  input  logic [2:0]              load_mode,
  input  logic [SYMBOL_WIDTH-1:0] load_const,
  output logic [SYMBOL_WIDTH-1:0] sym
);

  // Lower half ones, upper half zeros: a 50% duty "clock" on the line.
  localparam logic [SYMBOL_WIDTH-1:0] CLOCK_PAT =
    {{(SYMBOL_WIDTH/2){1'b0}}, {(SYMBOL_WIDTH/2){1'b1}}};

  logic [2:0] mode;
  logic       fb;

  // Fibonacci feedback: parity of the tapped bits, shifted in at bit 0.
  assign fb = ^(sym & LFSR_POLY);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sym  <= '0;
      mode <= PAT_PRBS;
    end else if (reload) begin
      mode <= load_mode;
      case (load_mode)
        PAT_PRBS:    sym <= SEED;
        PAT_CONST:   sym <= load_const;
        PAT_CLOCK:   sym <= CLOCK_PAT;
        PAT_COUNTER: sym <= '0;
        PAT_WALK:    sym <= SYMBOL_WIDTH'(1);
        default:     sym <= '0;
      endcase
    end else if (advance) begin
      case (mode)
        PAT_PRBS:    sym <= {sym[SYMBOL_WIDTH-2:0], fb};
        PAT_COUNTER: sym <= sym + SYMBOL_WIDTH'(1);
        PAT_WALK:    sym <= {sym[SYMBOL_WIDTH-2:0], sym[SYMBOL_WIDTH-1]};
        default:     sym <= sym; // CONST/CLOCK/unused modes are static
      endcase
    end
  end

endmodule

// File: rtl/tmds_pattern_gen.sv
// Multi-lane TMDS test-symbol generator. Drives CHANNELS lanes in lockstep
// into the serializer symbol FIFOs, optionally for a fixed-length burst.
// Ports:
//   clk_i, rst_i     logic clock, async active-high reset
//   start_i          latch config, reseed, begin run (also restarts RUN/DONE)
//   stop_i           abort to IDLE; wins over start_i
//   mode_i, const_i  pattern select / CONST symbol, sampled on start
//   burst_len_i      symbols per burst, 0 = continuous, sampled on start
//   fifo_full_i      per-lane FIFO full flags
//   write_o          per-lane write strobes (all equal)
//   symbols_o        lane c at [c*SYMBOL_WIDTH +: SYMBOL_WIDTH]
//   busy_o, done_o   RUN / DONE state flags
//   symbol_count_o   symbols written this run
module tmds_pattern_gen
  import tmds_pattern_gen_pkg::*;
#(
  parameter int                      CHANNELS     = 3,
  parameter int                      SYMBOL_WIDTH = 10,
  parameter logic [SYMBOL_WIDTH-1:0] LFSR_POLY    = 10'h240,
  parameter logic [SYMBOL_WIDTH-1:0] LFSR_SEED    = 10'h3FF,
  parameter int                      BURST_WIDTH  = 16
) (
  input  logic                             clk_i,
  input  logic                             rst_i,
  input  logic                             start_i,
  input  logic                             stop_i,
  input  logic [2:0]                       mode_i,
  input  logic [SYMBOL_WIDTH-1:0]          const_i,
  input  logic [BURST_WIDTH-1:0]           burst_len_i,
  input  logic [CHANNELS-1:0]              fifo_full_i,
  output logic [CHANNELS-1:0]              write_o,
  output logic [CHANNELS*SYMBOL_WIDTH-1:0] symbols_o,
  output logic                             busy_o,
  output logic                             done_o,
  output logic [BURST_WIDTH-1:0]           symbol_count_o
);

  state_t                                  state;
  logic [BURST_WIDTH-1:0]                  burst_len;
  logic [BURST_WIDTH-1:0]                  count;
  logic [BURST_WIDTH-1:0]                  count_next;
  logic                                    wr;
  logic                                    reload;
  logic                                    advance;
  logic [CHANNELS-1:0][SYMBOL_WIDTH-1:0]   lane_sym;

  // A single full lane stalls every lane so the streams stay aligned.
  assign wr         = (state == ST_RUN) && (fifo_full_i == '0);
  assign write_o    = {CHANNELS{wr}};
  assign reload     = start_i & ~stop_i;
  // The symbol just written is consumed; a same-cycle start/stop overrides.
  assign advance    = wr & ~start_i & ~stop_i;
  assign count_next = count + BURST_WIDTH'(1);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state     <= ST_IDLE;
      count     <= '0;
      burst_len <= '0;
    end else if (stop_i) begin
      state <= ST_IDLE;
    end else if (start_i) begin
      state     <= ST_RUN;
      count     <= '0;
      burst_len <= burst_len_i;
    end else if (advance) begin
      count <= count_next;
      if (burst_len != '0 && count_next == burst_len)
        state <= ST_DONE;
    end
  end

  assign busy_o         = (state == ST_RUN);
  assign done_o         = (state == ST_DONE);
  assign symbol_count_o = count;
  assign symbols_o      = lane_sym;

  for (genvar c = 0; c < CHANNELS; c++) begin : g_lane
    tmds_pattern_lane #(
      .SYMBOL_WIDTH (SYMBOL_WIDTH),
      .LFSR_POLY    (LFSR_POLY),
      .SEED         (LFSR_SEED ^ SYMBOL_WIDTH'(c))
    ) u_lane (
      .clk        (clk_i),
      .rst        (rst_i),
      .reload     (reload),
      .advance    (advance),
      .load_mode  (mode_i),
      .load_const (const_i),
      .sym        (lane_sym[c])
    );
  end

endmodule
